// File: rtl/ddr2_v10_1_seq_ram_pkg.sv
// Shared definitions for the sequencer-RAM Avalon-MM initiator:
// command opcodes, controller states and default bus widths.
package ddr2_v10_1_seq_ram_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FILL  = 2'b10,
        OP_CHECK = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WRITE      = 3'd1,
        ST_READ_ISSUE = 3'd2,
        ST_READ_CAP   = 3'd3,
        ST_FILL       = 3'd4,
        ST_CHK_ISSUE  = 3'd5,
        ST_CHK_DRAIN  = 3'd6,
        ST_DONE       = 3'd7
    } state_e;

endpackage

// File: rtl/ddr2_v10_1_sequencer_ram_master_if.sv
// Command port, RAM bus and result signals of the sequencer-RAM initiator.
// The master modport is the initiator's view; slave is the environment's.
interface ddr2_v10_1_sequencer_ram_master_if
    import ddr2_v10_1_seq_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BE_W   = DATA_W / 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W:0]   cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic [BE_W-1:0]   cmd_be;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              chipselect;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              clken;
    logic [DATA_W-1:0] readdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              done;
    logic [ADDR_W:0]   err_count;
    logic [ADDR_W-1:0] first_err_addr;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data, cmd_be, readdata,
        output cmd_ready, address, byteenable, chipselect, write, writedata, clken,
        output rsp_valid, rsp_data, done, err_count, first_err_addr
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_len, cmd_data, cmd_be, readdata,
        input  cmd_ready, address, byteenable, chipselect, write, writedata, clken,
        input  rsp_valid, rsp_data, done, err_count, first_err_addr
    );
endinterface

// File: rtl/ddr2_v10_1_seq_ram_chk.sv
// CHECK comparator: delays the issued expectation one cycle to line up with
// RAM readdata, counts mismatches (saturating) and latches the first bad address.
module ddr2_v10_1_seq_ram_chk #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              issue,
    input  logic [DATA_W-1:0] expected,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] readdata,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr
);
    localparam logic [ADDR_W:0] ERR_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ERR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] ERR_ZERO = {(ADDR_W+1){1'b0}};

    logic              vld_r;
    logic [DATA_W-1:0] exp_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W:0]   err_count_r;
    logic [ADDR_W-1:0] first_err_addr_r;
    logic              mismatch_s;

    assign mismatch_s     = vld_r && (readdata != exp_r);
    assign err_count      = err_count_r;
    assign first_err_addr = first_err_addr_r;

    // Delay line aligning the issued expectation with the returning readdata
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_r  <= 1'b0;
            exp_r  <= {DATA_W{1'b0}};
            addr_r <= {ADDR_W{1'b0}};
        end else begin
            vld_r  <= issue;
            exp_r  <= expected;
            addr_r <= addr;
        end
    end

    // Saturating mismatch counter and first-mismatch address latch
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count_r      <= ERR_ZERO;
            first_err_addr_r <= {ADDR_W{1'b0}};
        end else if (clear) begin
            err_count_r      <= ERR_ZERO;
            first_err_addr_r <= {ADDR_W{1'b0}};
        end else if (mismatch_s) begin
            if (err_count_r != ERR_MAX) begin
                err_count_r <= err_count_r + ERR_ONE;
            end
            if (err_count_r == ERR_ZERO) begin
                first_err_addr_r <= addr_r;
            end
        end
    end
endmodule

// File: rtl/ddr2_v10_1_sequencer_ram_master.sv
// Avalon-MM initiator for the sequencer RAM: single READ/WRITE plus a
// back-to-back FILL pattern writer and CHECK pattern reader.
module ddr2_v10_1_sequencer_ram_master
    import ddr2_v10_1_seq_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic clk,
    input  logic reset_n,
    ddr2_v10_1_sequencer_ram_master_if.master bus
);
    localparam logic [ADDR_W:0]   LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};
    localparam logic [BE_W-1:0]   BE_ALL   = {BE_W{1'b1}};

    state_e            state_r, state_s;
    logic              cmd_ready_r, clken_r;
    logic              cs_r, cs_s, write_r, write_s;
    logic [ADDR_W-1:0] address_r, address_s;
    logic [BE_W-1:0]   byteenable_r, byteenable_s;
    logic [DATA_W-1:0] writedata_r, writedata_s;
    logic [DATA_W-1:0] pat_r, pat_s, pat_inc_s;
    logic [ADDR_W:0]   rem_r, rem_s;
    logic [ADDR_W:0]   len_s, len_m1_s;
    logic              rsp_valid_r, rsp_valid_s, done_r, done_s;
    logic [DATA_W-1:0] rsp_data_r, rsp_data_s;
    logic              chk_clear_s, chk_issue_s;
    logic [ADDR_W:0]   err_count_s;
    logic [ADDR_W-1:0] first_err_addr_s;

    // Oversized sweeps cover the whole RAM exactly once
    assign len_s       = (bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len;
    assign len_m1_s    = len_s - LEN_ONE;
    assign pat_inc_s   = pat_r + DATA_ONE;
    assign chk_issue_s = (state_r == ST_CHK_ISSUE);

    // Next-state and next-output decode; bus outputs are registered from these
    always_comb begin
        state_s      = state_r;
        cs_s         = 1'b0;
        write_s      = 1'b0;
        address_s    = address_r;
        byteenable_s = byteenable_r;
        writedata_s  = writedata_r;
        pat_s        = pat_r;
        rem_s        = rem_r;
        rsp_valid_s  = 1'b0;
        rsp_data_s   = rsp_data_r;
        done_s       = 1'b0;
        chk_clear_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    case (op_e'(bus.cmd_op))
                        OP_READ: begin
                            state_s      = ST_READ_ISSUE;
                            cs_s         = 1'b1;
                            address_s    = bus.cmd_addr;
                            byteenable_s = BE_ALL;
                        end
                        OP_WRITE: begin
                            state_s      = ST_WRITE;
                            cs_s         = 1'b1;
                            write_s      = 1'b1;
                            address_s    = bus.cmd_addr;
                            byteenable_s = bus.cmd_be;
                            writedata_s  = bus.cmd_data;
                        end
                        OP_FILL: begin
                            if (len_s == LEN_ZERO) begin
                                state_s = ST_DONE;
                                done_s  = 1'b1;
                            end else begin
                                state_s      = ST_FILL;
                                cs_s         = 1'b1;
                                write_s      = 1'b1;
                                address_s    = bus.cmd_addr;
                                byteenable_s = BE_ALL;
                                writedata_s  = bus.cmd_data;
                                pat_s        = bus.cmd_data;
                                rem_s        = len_m1_s;
                            end
                        end
                        OP_CHECK: begin
                            chk_clear_s = 1'b1;
                            if (len_s == LEN_ZERO) begin
                                state_s = ST_DONE;
                                done_s  = 1'b1;
                            end else begin
                                state_s      = ST_CHK_ISSUE;
                                cs_s         = 1'b1;
                                address_s    = bus.cmd_addr;
                                byteenable_s = BE_ALL;
                                pat_s        = bus.cmd_data;
                                rem_s        = len_m1_s;
                            end
                        end
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_s = ST_DONE;
                done_s  = 1'b1;
            end
            ST_READ_ISSUE: state_s = ST_READ_CAP;
            ST_READ_CAP: begin
                state_s     = ST_DONE;
                rsp_valid_s = 1'b1;
                rsp_data_s  = bus.readdata;
                done_s      = 1'b1;
            end
            ST_FILL: begin
                if (rem_r == LEN_ZERO) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end else begin
                    cs_s        = 1'b1;
                    write_s     = 1'b1;
                    address_s   = address_r + ADDR_ONE;
                    writedata_s = pat_inc_s;
                    pat_s       = pat_inc_s;
                    rem_s       = rem_r - LEN_ONE;
                end
            end
            ST_CHK_ISSUE: begin
                if (rem_r == LEN_ZERO) begin
                    state_s = ST_CHK_DRAIN;
                end else begin
                    cs_s      = 1'b1;
                    address_s = address_r + ADDR_ONE;
                    pat_s     = pat_inc_s;
                    rem_s     = rem_r - LEN_ONE;
                end
            end
            ST_CHK_DRAIN: begin
                state_s = ST_DONE;
                done_s  = 1'b1;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and registered bus/response outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            cmd_ready_r  <= 1'b1;
            clken_r      <= 1'b0;
            cs_r         <= 1'b0;
            write_r      <= 1'b0;
            address_r    <= {ADDR_W{1'b0}};
            byteenable_r <= {BE_W{1'b0}};
            writedata_r  <= {DATA_W{1'b0}};
            pat_r        <= {DATA_W{1'b0}};
            rem_r        <= LEN_ZERO;
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= {DATA_W{1'b0}};
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            cmd_ready_r  <= (state_s == ST_IDLE);
            clken_r      <= 1'b1;
            cs_r         <= cs_s;
            write_r      <= write_s;
            address_r    <= address_s;
            byteenable_r <= byteenable_s;
            writedata_r  <= writedata_s;
            pat_r        <= pat_s;
            rem_r        <= rem_s;
            rsp_valid_r  <= rsp_valid_s;
            rsp_data_r   <= rsp_data_s;
            done_r       <= done_s;
        end
    end

    ddr2_v10_1_seq_ram_chk #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_chk (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear          (chk_clear_s),
        .issue          (chk_issue_s),
        .expected       (pat_r),
        .addr           (address_r),
        .readdata       (bus.readdata),
        .err_count      (err_count_s),
        .first_err_addr (first_err_addr_s)
    );

    assign bus.cmd_ready      = cmd_ready_r;
    assign bus.clken          = clken_r;
    assign bus.chipselect     = cs_r;
    assign bus.write          = write_r;
    assign bus.address        = address_r;
    assign bus.byteenable     = byteenable_r;
    assign bus.writedata      = writedata_r;
    assign bus.rsp_valid      = rsp_valid_r;
    assign bus.rsp_data       = rsp_data_r;
    assign bus.done           = done_r;
    assign bus.err_count      = err_count_s;
    assign bus.first_err_addr = first_err_addr_s;
endmodule

// File: tb/tb_ddr2_v10_1_sequencer_ram_master.sv
// Directed bench for the sequencer-RAM initiator with a behavioural 1024x32
// RAM (registered read address, unregistered output) on the bus.
module tb_ddr2_v10_1_sequencer_ram_master;
    import ddr2_v10_1_seq_ram_pkg::*;

    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [0:1023];
    logic [31:0] rd_q;
    logic [9:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          wr_cyc_q[$];

    ddr2_v10_1_sequencer_ram_master_if #(.ADDR_W(10), .DATA_W(32)) bus ();

    ddr2_v10_1_sequencer_ram_master dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: byte-enabled write, read data valid the cycle after the access
    always @(posedge clk) begin
        if (bus.clken && bus.chipselect) begin
            if (bus.write) begin
                for (int b = 0; b < 4; b++)
                    if (bus.byteenable[b]) mem[bus.address][8*b +: 8] <= bus.writedata[8*b +: 8];
            end else begin
                rd_q <= mem[bus.address];
            end
        end
    end
    assign bus.readdata = rd_q;

    task automatic wait_ready();
        int w = 0;
        while (bus.cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL cmd_ready_timeout actual=%b required=1", bus.cmd_ready);
        end
    endtask

    // Offer one command, then trace the bus until two cycles past its done pulse
    task automatic run_cmd(input logic [1:0] op, input logic [9:0] addr, input logic [10:0] len,
                           input logic [31:0] data, input logic [3:0] be, input int max_cyc,
                           output int done_at, output int n_done, output int cs_cnt, output int rv_at);
        done_at = -1; n_done = 0; cs_cnt = 0; rv_at = -1;
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        @(negedge clk);
        wait_ready();
        bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_len = len;
        bus.cmd_data = data; bus.cmd_be = be; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (bus.chipselect) begin
                cs_cnt++;
                if (bus.write) begin
                    wr_addr_q.push_back(bus.address);
                    wr_data_q.push_back(bus.writedata);
                    wr_cyc_q.push_back(k);
                end
            end
            if (bus.rsp_valid && rv_at < 0) rv_at = k;
            if (bus.done) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
            if (done_at >= 0 && k >= done_at + 2) break;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready actual=%b required=1", bus.cmd_ready); end
        checks++; if (bus.chipselect !== 1'b0 || bus.write !== 1'b0) begin errors++; $display("FAIL rst_cs_wr actual=%b%b required=00", bus.chipselect, bus.write); end
        checks++; if (bus.clken !== 1'b0) begin errors++; $display("FAIL rst_clken actual=%b required=0", bus.clken); end
        checks++; if (bus.done !== 1'b0 || bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_done_rv actual=%b%b required=00", bus.done, bus.rsp_valid); end
        checks++; if (bus.address !== 10'd0 || bus.rsp_data !== 32'd0 || bus.err_count !== 11'd0) begin errors++; $display("FAIL rst_values actual=%h/%h/%h required=0/0/0", bus.address, bus.rsp_data, bus.err_count); end
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.clken !== 1'b1) begin errors++; $display("FAIL clken_after_reset actual=%b required=1", bus.clken); end
    endtask

    task automatic test_write_read();
        int d, n, c, r;
        run_cmd(OP_WRITE, 10'd5, 11'd0, 32'hDEADBEEF, 4'hF, 20, d, n, c, r);
        checks++; if (d !== 1) begin errors++; $display("FAIL write_done_at actual=%0d required=1", d); end
        checks++; if (n !== 1 || c !== 1) begin errors++; $display("FAIL write_pulses actual=done%0d/cs%0d required=done1/cs1", n, c); end
        checks++; if (wr_data_q.size() != 1 || wr_data_q[0] !== 32'hDEADBEEF) begin errors++; $display("FAIL write_data actual=%0d words required=1 word DEADBEEF", wr_data_q.size()); end
        run_cmd(OP_READ, 10'd5, 11'd0, 32'd0, 4'h0, 20, d, n, c, r);
        checks++; if (r !== 2) begin errors++; $display("FAIL read_latency actual=%0d required=2", r); end
        checks++; if (bus.rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data actual=%h required=deadbeef", bus.rsp_data); end
        checks++; if (n !== 1 || d !== 2 || c !== 1) begin errors++; $display("FAIL read_done actual=n%0d/at%0d/cs%0d required=n1/at2/cs1", n, d, c); end
    endtask

    task automatic test_byte_enable();
        int d, n, c, r;
        run_cmd(OP_WRITE, 10'd5, 11'd0, 32'h11223344, 4'b0101, 20, d, n, c, r);
        run_cmd(OP_READ, 10'd5, 11'd0, 32'd0, 4'h0, 20, d, n, c, r);
        checks++; if (bus.rsp_data !== 32'hDE22BE44) begin errors++; $display("FAIL byte_enable actual=%h required=de22be44", bus.rsp_data); end
    endtask

    task automatic test_fill_wrap();
        int d, n, c, r;
        logic [9:0] ea [4];
        ea = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        run_cmd(OP_FILL, 10'd1022, 11'd4, 32'h100, 4'h0, 20, d, n, c, r);
        checks++; if (wr_addr_q.size() != 4 || c !== 4) begin errors++; $display("FAIL fill_count actual=%0d writes/%0d cs required=4/4", wr_addr_q.size(), c); end
        for (int i = 0; i < 4; i++) begin
            if (i < wr_addr_q.size()) begin
                checks++;
                if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== 32'h100 + i || wr_cyc_q[i] !== i) begin
                    errors++; $display("FAIL fill_word%0d actual=%0d:%h@%0d required=%0d:%h@%0d", i, wr_addr_q[i], wr_data_q[i], wr_cyc_q[i], ea[i], 32'h100 + i, i);
                end
            end
        end
        checks++; if (d !== 4 || n !== 1) begin errors++; $display("FAIL fill_done actual=at%0d/n%0d required=at4/n1", d, n); end
        run_cmd(OP_CHECK, 10'd1022, 11'd4, 32'h100, 4'h0, 20, d, n, c, r);
        checks++; if (c !== 4 || wr_addr_q.size() != 0) begin errors++; $display("FAIL check_reads actual=%0d cs/%0d writes required=4/0", c, wr_addr_q.size()); end
        checks++; if (d !== 5) begin errors++; $display("FAIL check_done_at actual=%0d required=5", d); end
        checks++; if (bus.err_count !== 11'd0) begin errors++; $display("FAIL check_clean actual=%0d required=0", bus.err_count); end
    endtask

    task automatic test_check_mismatch();
        int d, n, c, r;
        run_cmd(OP_WRITE, 10'd0, 11'd0, 32'd0, 4'hF, 20, d, n, c, r);
        run_cmd(OP_CHECK, 10'd1022, 11'd4, 32'h100, 4'h0, 20, d, n, c, r);
        checks++; if (bus.err_count !== 11'd1) begin errors++; $display("FAIL mismatch_count actual=%0d required=1", bus.err_count); end
        checks++; if (bus.first_err_addr !== 10'd0) begin errors++; $display("FAIL mismatch_addr actual=%0d required=0", bus.first_err_addr); end
        run_cmd(OP_READ, 10'd1023, 11'd0, 32'd0, 4'h0, 20, d, n, c, r);
        checks++; if (bus.err_count !== 11'd1 || bus.rsp_data !== 32'h101) begin errors++; $display("FAIL err_hold actual=%0d/%h required=1/00000101", bus.err_count, bus.rsp_data); end
    endtask

    task automatic test_len_zero();
        int d, n, c, r;
        run_cmd(OP_FILL, 10'd7, 11'd0, 32'h55, 4'h0, 20, d, n, c, r);
        checks++; if (d !== 0 || c !== 0 || n !== 1) begin errors++; $display("FAIL fill_len0 actual=at%0d/cs%0d/n%0d required=at0/cs0/n1", d, c, n); end
        run_cmd(OP_CHECK, 10'd7, 11'd0, 32'h55, 4'h0, 20, d, n, c, r);
        checks++; if (d !== 0 || c !== 0 || bus.err_count !== 11'd0) begin errors++; $display("FAIL check_len0 actual=at%0d/cs%0d/err%0d required=at0/cs0/err0", d, c, bus.err_count); end
    endtask

    task automatic test_len_clamp();
        int d, n, c, r;
        run_cmd(OP_FILL, 10'd0, 11'd2000, 32'h5000, 4'h0, 1100, d, n, c, r);
        checks++; if (c !== 1024 || d !== 1024) begin errors++; $display("FAIL fill_clamp actual=cs%0d/at%0d required=cs1024/at1024", c, d); end
        run_cmd(OP_CHECK, 10'd0, 11'd2000, 32'h5000, 4'h0, 1100, d, n, c, r);
        checks++; if (c !== 1024 || d !== 1025 || bus.err_count !== 11'd0) begin errors++; $display("FAIL check_clamp actual=cs%0d/at%0d/err%0d required=cs1024/at1025/err0", c, d, bus.err_count); end
        run_cmd(OP_CHECK, 10'd3, 11'd2047, 32'h9000, 4'h0, 1100, d, n, c, r);
        checks++; if (bus.err_count !== 11'd1024 || bus.first_err_addr !== 10'd3) begin errors++; $display("FAIL check_all_bad actual=%0d@%0d required=1024@3", bus.err_count, bus.first_err_addr); end
    endtask

    task automatic test_reset_mid();
        int d, n, c, r, nd;
        @(negedge clk);
        wait_ready();
        bus.cmd_op = OP_FILL; bus.cmd_addr = 10'd100; bus.cmd_len = 11'd10;
        bus.cmd_data = 32'd0; bus.cmd_be = 4'h0; bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (bus.chipselect !== 1'b1 || bus.write !== 1'b1 || bus.address !== 10'd103) begin errors++; $display("FAIL mid_word3 actual=%b%b@%0d required=11@103", bus.chipselect, bus.write, bus.address); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.chipselect !== 1'b0 || bus.write !== 1'b0) begin errors++; $display("FAIL mid_async_drop actual=%b%b required=00", bus.chipselect, bus.write); end
        checks++; if (bus.cmd_ready !== 1'b1 || bus.err_count !== 11'd0 || bus.rsp_data !== 32'd0) begin errors++; $display("FAIL mid_reset_vals actual=%b/%0d/%h required=1/0/0", bus.cmd_ready, bus.err_count, bus.rsp_data); end
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL mid_no_done actual=%0d required=0", nd); end
        reset_n = 1'b1;
        run_cmd(OP_READ, 10'd102, 11'd0, 32'd0, 4'h0, 20, d, n, c, r);
        checks++; if (bus.rsp_data !== 32'd2 || r !== 2) begin errors++; $display("FAIL post_reset_read102 actual=%h@%0d required=00000002@2", bus.rsp_data, r); end
        run_cmd(OP_READ, 10'd103, 11'd0, 32'd0, 4'h0, 20, d, n, c, r);
        checks++; if (bus.rsp_data !== 32'h5067 || d !== 2) begin errors++; $display("FAIL post_reset_read103 actual=%h@%0d required=00005067@2", bus.rsp_data, d); end
    endtask

    initial begin
        reset_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = 10'd0;
        bus.cmd_len   = 11'd0;
        bus.cmd_data  = 32'd0;
        bus.cmd_be    = 4'h0;
        repeat (3) @(negedge clk);
        test_reset();
        test_write_read();
        test_byte_enable();
        test_fill_wrap();
        test_check_mismatch();
        test_len_zero();
        test_len_clamp();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
